// File: rtl/clock_pkg.sv
// Shared clock/alarm definitions: field limits, alarm FSM encoding and
// wrapping increment helpers used by the time registers.
package clock_pkg;

  localparam logic [4:0] HOURS_MAX   = 5'd23;
  localparam logic [5:0] MINUTES_MAX = 6'd59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_t;

  function automatic logic [4:0] inc_hours(input logic [4:0] h);
    return (h >= HOURS_MAX) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] inc_minutes(input logic [5:0] m);
    return (m >= MINUTES_MAX) ? 6'd0 : m + 6'd1;
  endfunction

endpackage

// File: rtl/alarm_time_register.sv
// User-settable alarm time. Each field wraps independently; minutes never
// carry into hours so the user can reach any value by editing one field.
module alarm_time_register
  import clock_pkg::*;
#(
  parameter logic [4:0] DEFAULT_HOURS   = 5'd6,
  parameter logic [5:0] DEFAULT_MINUTES = 6'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_stb,
  input  logic       alarm_set,
  input  logic       set_hours,
  input  logic       set_minutes,
  output logic [4:0] hours,
  output logic [5:0] minutes
);

  always_ff @(posedge clk) begin
    if (reset) begin
      hours   <= DEFAULT_HOURS;
      minutes <= DEFAULT_MINUTES;
    end else if (alarm_set && set_stb) begin
      if (set_hours)   hours   <= inc_hours(hours);
      if (set_minutes) minutes <= inc_minutes(minutes);
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// Alarm stage: compares running time with the alarm time, rings once per
// match minute, supports snooze and auto-silences after a timeout.
module alarm_controller
  import clock_pkg::*;
#(
  parameter int unsigned SNOOZE_S        = 540,
  parameter int unsigned RING_TIMEOUT_S  = 3600,
  parameter int unsigned DEFAULT_HOURS   = 6,
  parameter int unsigned DEFAULT_MINUTES = 0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_1hz_stb,
  input  logic       i_set_stb,
  input  logic [4:0] i_hours,
  input  logic [5:0] i_minutes,
  input  logic [5:0] i_seconds,
  input  logic       i_alarm_set,
  input  logic       i_set_hours,
  input  logic       i_set_minutes,
  input  logic       i_alarm_en,
  input  logic       i_snooze,
  output logic [4:0] o_alarm_hours,
  output logic [5:0] o_alarm_minutes,
  output logic       o_armed,
  output logic       o_ringing,
  output logic       o_snoozing,
  output logic       o_buzzer
);

  localparam logic [11:0] RING_LOAD   = 12'(RING_TIMEOUT_S - 1);
  localparam logic [11:0] SNOOZE_LOAD = 12'(SNOOZE_S - 1);

  alarm_state_t state, state_n;
  logic [11:0]  ring_cnt, ring_cnt_n;
  logic [11:0]  snooze_cnt, snooze_cnt_n;
  logic         beep_phase, beep_phase_n;
  logic         match, match_q, snooze_q;
  logic         time_hit, trigger, snooze_edge;

  alarm_time_register #(
    .DEFAULT_HOURS  (5'(DEFAULT_HOURS)),
    .DEFAULT_MINUTES(6'(DEFAULT_MINUTES))
  ) u_alarm_time (
    .clk        (i_clk),
    .reset      (i_reset),
    .set_stb    (i_set_stb),
    .alarm_set  (i_alarm_set),
    .set_hours  (i_set_hours),
    .set_minutes(i_set_minutes),
    .hours      (o_alarm_hours),
    .minutes    (o_alarm_minutes)
  );

  assign time_hit = (i_hours == o_alarm_hours) && (i_minutes == o_alarm_minutes)
                    && (i_seconds == 6'd0);
  // Held set buttons mean the user is moving the clock; landing on the alarm
  // time that way must not ring, and match_q then blocks it after release.
  assign trigger = match && !match_q && o_armed && !i_alarm_set
                   && !i_set_hours && !i_set_minutes;
  assign snooze_edge = i_snooze && !snooze_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      ring_cnt   <= '0;
      snooze_cnt <= '0;
      beep_phase <= 1'b0;
      match      <= 1'b0;
      match_q    <= 1'b0;
      snooze_q   <= 1'b0;
      o_armed    <= 1'b0;
    end else begin
      state      <= state_n;
      ring_cnt   <= ring_cnt_n;
      snooze_cnt <= snooze_cnt_n;
      beep_phase <= beep_phase_n;
      match      <= time_hit;
      match_q    <= match;
      snooze_q   <= i_snooze;
      o_armed    <= i_alarm_en;
    end
  end

  always_comb begin
    state_n      = state;
    ring_cnt_n   = ring_cnt;
    snooze_cnt_n = snooze_cnt;
    beep_phase_n = beep_phase;
    if (!i_alarm_en || i_alarm_set) begin
      state_n      = IDLE;
      ring_cnt_n   = '0;
      snooze_cnt_n = '0;
      beep_phase_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state_n      = RINGING;
            ring_cnt_n   = RING_LOAD;
            beep_phase_n = 1'b1;
          end
        end
        RINGING: begin
          if (snooze_edge) begin
            state_n      = SNOOZE;
            snooze_cnt_n = SNOOZE_LOAD;
            beep_phase_n = 1'b0;
          end else if (i_1hz_stb) begin
            if (ring_cnt == 12'd0) begin
              state_n      = IDLE;
              beep_phase_n = 1'b0;
            end else begin
              ring_cnt_n   = ring_cnt - 12'd1;
              beep_phase_n = !beep_phase;
            end
          end
        end
        SNOOZE: begin
          if (i_1hz_stb) begin
            if (snooze_cnt == 12'd0) begin
              state_n      = RINGING;
              ring_cnt_n   = RING_LOAD;
              beep_phase_n = 1'b1;
            end else begin
              snooze_cnt_n = snooze_cnt - 12'd1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    o_ringing  = (state == RINGING);
    o_snoozing = (state == SNOOZE);
    o_buzzer   = (state == RINGING) && beep_phase;
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: alarm editing, fire/timeout, snooze,
// disarm, reset mid-snooze and clock-set suppression.
module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       hz_stb = 1'b0;
  logic       set_stb = 1'b0;
  logic [4:0] hours = 5'd5;
  logic [5:0] minutes = 6'd59;
  logic [5:0] seconds = 6'd59;
  logic       alarm_set = 1'b0;
  logic       set_hours = 1'b0;
  logic       set_minutes = 1'b0;
  logic       alarm_en = 1'b0;
  logic       snooze = 1'b0;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       armed, ringing, snoozing, buzzer;

  int tests_run = 0;
  int tests_failed = 0;

  alarm_controller dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_1hz_stb      (hz_stb),
    .i_set_stb      (set_stb),
    .i_hours        (hours),
    .i_minutes      (minutes),
    .i_seconds      (seconds),
    .i_alarm_set    (alarm_set),
    .i_set_hours    (set_hours),
    .i_set_minutes  (set_minutes),
    .i_alarm_en     (alarm_en),
    .i_snooze       (snooze),
    .o_alarm_hours  (alarm_hours),
    .o_alarm_minutes(alarm_minutes),
    .o_armed        (armed),
    .o_ringing      (ringing),
    .o_snoozing     (snoozing),
    .o_buzzer       (buzzer)
  );

  // clock / reset
  always #50 clk = ~clk;

  // Advance one active edge; inputs are changed and outputs sampled 1 ns later.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_1hz(input int n = 1);
    repeat (n) begin
      hz_stb = 1'b1;
      tick();
      hz_stb = 1'b0;
    end
  endtask

  task automatic pulse_set(input int n = 1);
    repeat (n) begin
      set_stb = 1'b1;
      tick();
      set_stb = 1'b0;
    end
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    hours = h; minutes = m; seconds = s;
  endtask

  initial begin
    // reset defaults
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check("rst_hours", alarm_hours, 6);
    check("rst_minutes", alarm_minutes, 0);
    check("rst_ringing", ringing, 0);
    check("rst_buzzer", buzzer, 0);
    check("rst_armed", armed, 0);
    check("rst_snoozing", snoozing, 0);

    // alarm edit with wrap
    alarm_set = 1'b1;
    set_minutes = 1'b1;
    pulse_set(1);
    check("set_min_1", alarm_minutes, 1);
    pulse_set(58);
    check("set_min_59", alarm_minutes, 59);
    pulse_set(1);
    check("set_min_wrap", alarm_minutes, 0);
    check("set_min_nocarry", alarm_hours, 6);
    pulse_set(1);
    check("set_min_61", alarm_minutes, 1);
    set_minutes = 1'b0;
    set_hours = 1'b1;
    pulse_set(17);
    check("set_hr_23", alarm_hours, 23);
    pulse_set(1);
    check("set_hr_wrap", alarm_hours, 0);
    check("set_hr_min", alarm_minutes, 1);
    set_minutes = 1'b1;
    pulse_set(1);
    check("set_both_h", alarm_hours, 1);
    check("set_both_m", alarm_minutes, 2);
    alarm_set = 1'b0;
    pulse_set(1);
    check("set_gated_h", alarm_hours, 1);
    check("set_gated_m", alarm_minutes, 2);
    set_hours = 1'b0;
    set_minutes = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_hours", alarm_hours, 6);
    check("rst2_minutes", alarm_minutes, 0);

    // fire and timeout
    alarm_en = 1'b1;
    tick();
    check("armed", armed, 1);
    set_time(5'd6, 6'd0, 6'd0);
    tick();
    check("fire_lat1", ringing, 0);
    tick();
    check("fire_ringing", ringing, 1);
    check("fire_buzzer", buzzer, 1);
    seconds = 6'd1;
    pulse_1hz(1);
    check("beep_off", buzzer, 0);
    pulse_1hz(1);
    check("beep_on", buzzer, 1);
    pulse_1hz(3597);
    check("ring_3599", ringing, 1);
    check("beep_3599", buzzer, 0);
    pulse_1hz(1);
    check("timeout_ringing", ringing, 0);
    check("timeout_buzzer", buzzer, 0);

    // snooze
    set_time(5'd5, 6'd59, 6'd59);
    tick();
    set_time(5'd6, 6'd0, 6'd0);
    tick(2);
    check("re_fire", ringing, 1);
    seconds = 6'd1;
    snooze = 1'b1;
    pulse_1hz(1);
    check("snooze_state", snoozing, 1);
    check("snooze_ringing", ringing, 0);
    check("snooze_buzzer", buzzer, 0);
    pulse_1hz(539);
    check("snooze_539", snoozing, 1);
    pulse_1hz(1);
    check("snooze_end_ring", ringing, 1);
    check("snooze_end_buzz", buzzer, 1);
    pulse_1hz(1);
    check("hold_no_resnooze", snoozing, 0);
    check("hold_ringing", ringing, 1);
    check("hold_buzzer", buzzer, 0);
    snooze = 1'b0;

    // disarm mid-ring, re-arm within the match minute
    alarm_en = 1'b0;
    tick();
    check("disarm_ringing", ringing, 0);
    set_time(5'd5, 6'd59, 6'd59);
    tick();
    set_time(5'd6, 6'd0, 6'd0);
    tick(2);
    alarm_en = 1'b1;
    tick(4);
    check("rearm_no_fire", ringing, 0);
    seconds = 6'd1;

    // reset mid-snooze with a non-default alarm time
    alarm_set = 1'b1;
    set_hours = 1'b1;
    pulse_set(1);
    alarm_set = 1'b0;
    set_hours = 1'b0;
    tick();
    check("alarm_7", alarm_hours, 7);
    set_time(5'd6, 6'd59, 6'd59);
    tick();
    set_time(5'd7, 6'd0, 6'd0);
    tick(2);
    check("fire_7", ringing, 1);
    seconds = 6'd1;
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    check("snooze_7", snoozing, 1);
    pulse_1hz(3);
    check("snooze_7_hold", snoozing, 1);
    set_time(5'd5, 6'd0, 6'd0);
    reset = 1'b1;
    tick();
    check("rst3_snoozing", snoozing, 0);
    check("rst3_ringing", ringing, 0);
    check("rst3_buzzer", buzzer, 0);
    check("rst3_armed", armed, 0);
    check("rst3_hours", alarm_hours, 6);
    check("rst3_minutes", alarm_minutes, 0);
    reset = 1'b0;
    tick(3);

    // setting the clock onto the alarm time does not trigger
    set_minutes = 1'b1;
    set_time(5'd6, 6'd0, 6'd0);
    tick(3);
    check("clkset_held", ringing, 0);
    set_minutes = 1'b0;
    tick(3);
    check("clkset_release", ringing, 0);
    check("clkset_alarm_m", alarm_minutes, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
